// File: rtl/data_memory_mc_if.sv
// -----------------------------------------------------------------------------
// data_memory_mc_if
// Request/response bundle between a MIPS core and the multi-cycle data memory.
//   req        : access request, honoured only while busy=0
//   write      : 1=store, 0=load (qualified by req)
//   size       : 00=byte, 01=halfword, 1x=word
//   sign_ext   : loads only, 1=sign-extend byte/half result
//   addr_in    : byte address (upper bits beyond the array alias)
//   data_in    : right-justified store data
//   data_out   : registered load result
//   busy       : request in flight
//   done       : one-cycle completion pulse
//   misaligned : qualified by done, request rejected for alignment
// master = core side, slave = memory side.
// -----------------------------------------------------------------------------
interface data_memory_mc_if;
    logic        req;
    logic        write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport master (
        output req, write, size, sign_ext, addr_in, data_in,
        input  data_out, busy, done, misaligned
    );

    modport slave (
        input  req, write, size, sign_ext, addr_in, data_in,
        output data_out, busy, done, misaligned
    );
endinterface

// File: rtl/data_memory_mc.sv
// -----------------------------------------------------------------------------
// data_memory_mc
// Multi-cycle, byte-addressable, little-endian 32-bit data memory with
// byte/half/word access, load sign/zero extension, alignment checking and
// WAIT_STATES extra cycles behind a req/busy/done handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (control state and data_out only;
//           the byte array keeps its contents)
//   bus   : data_memory_mc_if.slave request/response bundle
// Sequence per request: IDLE --accept--> WAIT (WAIT_STATES cycles) -->
// ACCESS (1 cycle, memory touched at its closing edge) --> IDLE with done=1.
// -----------------------------------------------------------------------------
module data_memory_mc #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    data_memory_mc_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;

    // Request fields captured at acceptance.
    logic                 write_q;
    logic [1:0]           size_q;
    logic                 sign_ext_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;

    logic [31:0]          data_out_q;
    logic                 done_q;
    logic                 misaligned_q;

    logic [7:0]           mem [DEPTH];

    logic                 accept;
    logic                 access;
    logic                 bad_align;
    logic [ADDR_BITS-1:0] a0, a1, a2, a3;
    logic [31:0]          raw_word;

    // Address bits above the array are intentionally ignored (aliasing).
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_in[31:ADDR_BITS];

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0]  size,
                                                input logic        sext,
                                                input logic [31:0] raw);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{sext & raw[7]}}, raw[7:0]};
            2'b01:   r = {{16{sext & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign accept    = (state_q == ST_IDLE) && bus.req;
    assign access    = (state_q == ST_ACCESS);
    assign bad_align = is_misaligned(size_q, addr_q[1:0]);

    // Byte lanes wrap inside the array; aligned accesses never actually wrap.
    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_BITS'(1);
    assign a2 = addr_q + ADDR_BITS'(2);
    assign a3 = addr_q + ADDR_BITS'(3);
    assign raw_word = {mem[a3], mem[a2], mem[a1], mem[a0]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter was loaded with WS; the WS-th WAIT edge moves on.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control registers and load result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            data_out_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= access;
            misaligned_q <= access && bad_align;
            if (access && !write_q && !bad_align) begin
                data_out_q <= extend_load(size_q, sign_ext_q, raw_word);
            end
        end
    end

    // Request capture; harmless during reset because the FSM re-captures on
    // the next acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q    <= bus.write;
            size_q     <= bus.size;
            sign_ext_q <= bus.sign_ext;
            addr_q     <= bus.addr_in[ADDR_BITS-1:0];
            wdata_q    <= bus.data_in;
        end
    end

    // Byte array; an aborted (reset) or misaligned store leaves it untouched.
    always_ff @(posedge clk) begin
        if (!reset && access && write_q && !bad_align) begin
            mem[a0] <= wdata_q[7:0];
            if (size_q != 2'b00) begin
                mem[a1] <= wdata_q[15:8];
            end
            if (size_q[1]) begin
                mem[a2] <= wdata_q[23:16];
                mem[a3] <= wdata_q[31:24];
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.misaligned = misaligned_q;
    assign bus.data_out   = data_out_q;
endmodule

// File: tb/tb_data_memory_mc.sv
module tb_data_memory_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_s, write_s, se_s;
    logic [1:0]  size_s;
    logic [31:0] addr_s, data_s;
    int          sel;

    int n_vec = 0;
    int n_bad = 0;

    data_memory_mc_if bus0 ();
    data_memory_mc_if bus1 ();
    data_memory_mc_if bus2 ();

    assign bus0.req = req_s && (sel == 0);
    assign bus1.req = req_s && (sel == 1);
    assign bus2.req = req_s && (sel == 2);
    assign bus0.write = write_s;  assign bus1.write = write_s;  assign bus2.write = write_s;
    assign bus0.size = size_s;    assign bus1.size = size_s;    assign bus2.size = size_s;
    assign bus0.sign_ext = se_s;  assign bus1.sign_ext = se_s;  assign bus2.sign_ext = se_s;
    assign bus0.addr_in = addr_s; assign bus1.addr_in = addr_s; assign bus2.addr_in = addr_s;
    assign bus0.data_in = data_s; assign bus1.data_in = data_s; assign bus2.data_in = data_s;

    data_memory_mc #(.ADDR_BITS(10), .WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(reset), .bus(bus0));
    data_memory_mc #(.ADDR_BITS(10), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(bus1));
    data_memory_mc #(.ADDR_BITS(10), .WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(reset), .bus(bus2));

    logic        busy_a [3];
    logic        done_a [3];
    logic        mis_a  [3];
    logic [31:0] dout_a [3];
    assign busy_a[0] = bus0.busy; assign done_a[0] = bus0.done; assign mis_a[0] = bus0.misaligned; assign dout_a[0] = bus0.data_out;
    assign busy_a[1] = bus1.busy; assign done_a[1] = bus1.done; assign mis_a[1] = bus1.misaligned; assign dout_a[1] = bus1.data_out;
    assign busy_a[2] = bus2.busy; assign done_a[2] = bus2.done; assign mis_a[2] = bus2.misaligned; assign dout_a[2] = bus2.data_out;

    logic        busy_m, done_m, mis_m;
    logic [31:0] dout_m;
    assign busy_m = busy_a[sel];
    assign done_m = done_a[sel];
    assign mis_m  = mis_a[sel];
    assign dout_m = dout_a[sel];

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request accepted at edge c (block idle, req high) completes at edge
    // c+WS+1; done/misaligned/data_out reflect it during the following cycle.
    logic [7:0]  mm [3][1024];
    bit          pend [3];
    int          done_edge [3];
    bit          t_w [3];
    bit          t_se [3];
    logic [1:0]  t_sz [3];
    logic [31:0] t_a [3];
    logic [31:0] t_d [3];
    bit          e_busy [3];
    bit          e_done [3];
    bit          e_mis [3];
    logic [31:0] e_dout [3];
    bit          started = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        int a, n;
        logic [31:0] v;
        bit rk, was, bad;
        #1;
        cyc++;
        if (reset) started = 1;
        for (int k = 0; k < 3; k++) begin
            rk  = req_s && (sel == k);
            was = pend[k];
            if (reset) begin
                pend[k] = 0; e_done[k] = 0; e_mis[k] = 0; e_dout[k] = 32'd0;
            end else begin
                e_done[k] = 0;
                e_mis[k]  = 0;
                if (was && cyc == done_edge[k]) begin
                    pend[k] = 0;
                    a   = int'(t_a[k] % 1024);
                    n   = (t_sz[k] == 2'b00) ? 1 : (t_sz[k] == 2'b01) ? 2 : 4;
                    bad = (a % n) != 0;
                    e_done[k] = 1;
                    e_mis[k]  = bad;
                    if (!bad) begin
                        if (t_w[k]) begin
                            for (int i = 0; i < n; i++) mm[k][(a + i) % 1024] = t_d[k][8*i +: 8];
                        end else begin
                            v = 32'd0;
                            for (int i = 0; i < n; i++) v = v | (32'(mm[k][(a + i) % 1024]) << (8 * i));
                            if (n < 4 && t_se[k] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                            e_dout[k] = v;
                        end
                    end
                end
                if (!was && rk) begin
                    pend[k] = 1;
                    done_edge[k] = cyc + ws_of(k) + 1;
                    t_w[k] = write_s; t_se[k] = se_s; t_sz[k] = size_s;
                    t_a[k] = addr_s;  t_d[k] = data_s;
                end
            end
            e_busy[k] = pend[k];
            if (started) begin
                chk("busy", k, 32'(busy_a[k]), 32'(e_busy[k]));
                chk("done", k, 32'(done_a[k]), 32'(e_done[k]));
                chk("data_out", k, dout_a[k], e_dout[k]);
                if (e_done[k]) chk("misaligned", k, 32'(mis_a[k]), 32'(e_mis[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input bit w, input logic [1:0] sz, input bit se, input logic [31:0] a,
                       input logic [31:0] d, input bit pulse,
                       output logic [31:0] rd, output logic rmis);
        int g, lat;
        bit got;
        @(negedge clk);
        g = 0;
        while (busy_m && g < 50) begin @(negedge clk); g++; end
        write_s = w; size_s = sz; se_s = se; addr_s = a; data_s = d; req_s = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (pulse) begin
                    // Competing word store while busy; must be dropped.
                    write_s = 1'b1; size_s = 2'b10; addr_s = 32'h40; data_s = 32'h12345678;
                end else begin
                    req_s = 1'b0;
                end
            end else if (lat == 2) begin
                req_s = 1'b0;
            end
            got = done_m;
        end
        req_s = 1'b0;
        if (!got) chk("done_timeout", sel, 32'd0, 32'd1);
        else chk("latency", sel, 32'(lat), 32'(ws_of(sel) + 2));
        rd = dout_m;
        rmis = mis_m;
    endtask

    initial begin
        logic [31:0] rd;
        logic rmis;
        int k, first, second, span;
        bit any_done;

        reset = 1'b1; req_s = 1'b0; write_s = 1'b0; se_s = 1'b0;
        size_s = 2'b00; addr_s = 32'd0; data_s = 32'd0; sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 0, 32'(busy_m), 32'd0);
        chk("rst_done", 0, 32'(done_m), 32'd0);
        chk("rst_dout", 0, dout_m, 32'd0);

        // Preload
        txn(1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, rd, rmis);
        txn(1, 2'b10, 0, 32'h50, 32'h55667788, 0, rd, rmis);

        // Word store / load
        txn(1, 2'b10, 0, 32'h10, 32'h11223344, 0, rd, rmis);
        chk("st_keeps_dout", 0, rd, 32'd0);
        txn(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, rmis);
        chk("ld_word", 0, rd, 32'h11223344);
        txn(0, 2'b00, 0, 32'h10, 32'h0, 0, rd, rmis);
        chk("ld_byte10", 0, rd, 32'h00000044);

        // Byte store, signed/unsigned byte loads
        txn(1, 2'b00, 0, 32'h13, 32'hFFFFFF80, 0, rd, rmis);
        txn(0, 2'b00, 1, 32'h13, 32'h0, 0, rd, rmis);
        chk("ld_sbyte", 0, rd, 32'hFFFFFF80);
        txn(0, 2'b00, 0, 32'h13, 32'h0, 0, rd, rmis);
        chk("ld_ubyte", 0, rd, 32'h00000080);
        txn(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, rmis);
        chk("ld_word2", 0, rd, 32'h80223344);

        // Halfword, misalignment
        txn(1, 2'b01, 0, 32'h22, 32'h0000BEEF, 0, rd, rmis);
        txn(0, 2'b01, 1, 32'h22, 32'h0, 0, rd, rmis);
        chk("ld_shalf", 0, rd, 32'hFFFFBEEF);
        txn(0, 2'b01, 0, 32'h21, 32'h0, 0, rd, rmis);
        chk("mis_half_flag", 0, 32'(rmis), 32'd1);
        chk("mis_half_dout", 0, rd, 32'hFFFFBEEF);
        txn(1, 2'b01, 0, 32'h23, 32'h00001234, 0, rd, rmis);
        chk("mis_st_flag", 0, 32'(rmis), 32'd1);
        txn(0, 2'b10, 0, 32'h12, 32'h0, 0, rd, rmis);
        chk("mis_word_flag", 0, 32'(rmis), 32'd1);
        txn(0, 2'b01, 0, 32'h22, 32'h0, 0, rd, rmis);
        chk("ld_uhalf", 0, rd, 32'h0000BEEF);
        txn(0, 2'b11, 0, 32'h10, 32'h0, 0, rd, rmis);
        chk("ld_size11", 0, rd, 32'h80223344);

        // Req pulsed while busy is dropped
        txn(0, 2'b10, 0, 32'h10, 32'h0, 1, rd, rmis);
        txn(0, 2'b10, 0, 32'h40, 32'h0, 0, rd, rmis);
        chk("dropped_req", 0, rd, 32'hCAFEF00D);

        // Back-to-back with req held across done
        @(negedge clk);
        write_s = 1'b0; size_s = 2'b10; se_s = 1'b0; addr_s = 32'h10; req_s = 1'b1;
        k = 0; first = -1; second = -1;
        while (second < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (done_m) begin
                if (first < 0) first = k;
                else begin second = k; req_s = 1'b0; end
            end
        end
        req_s = 1'b0;
        span = second - first;
        chk("b2b_first", 0, 32'(first), 32'd3);
        chk("b2b_interval", 0, 32'(span), 32'd3);
        chk("b2b_data", 0, dout_m, 32'h80223344);

        // Aliasing
        txn(1, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, rd, rmis);
        txn(0, 2'b10, 0, 32'h400, 32'h0, 0, rd, rmis);
        chk("alias", 0, rd, 32'hDEADBEEF);

        // Other wait-state settings: preload, latency, load
        for (int s = 1; s < 3; s++) begin
            @(negedge clk);
            sel = s;
            txn(1, 2'b10, 0, 32'h50, 32'h55667788, 0, rd, rmis);
            txn(0, 2'b10, 0, 32'h50, 32'h0, 0, rd, rmis);
            chk("ws_load", s, rd, 32'h55667788);
        end

        // Reset aborts an in-flight store
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            sel = s;
            @(negedge clk);
            write_s = 1'b1; size_s = 2'b10; addr_s = 32'h50; data_s = 32'h99999999; req_s = 1'b1;
            @(negedge clk);
            req_s = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("abort_busy", s, 32'(busy_m), 32'd0);
            chk("abort_dout", s, dout_m, 32'd0);
            any_done = 0;
            for (int i = 0; i < 2 * ws_of(s) + 4; i++) begin
                @(negedge clk);
                if (done_m) any_done = 1;
            end
            chk("abort_no_done", s, 32'(any_done), 32'd0);
            txn(0, 2'b10, 0, 32'h50, 32'h0, 0, rd, rmis);
            chk("abort_mem", s, rd, 32'h55667788);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
